// File: rtl/instruction_fetch.sv
// instruction_fetch: PC-owning fetch stage feeding the execute stage over valid/stall.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   run_i                level fetch enable
//   stall_i              downstream not ready; holds the presented instruction
//   jump_en_i/jump_addr_i load PC and flush the presented instruction
//   pm_addr_o/pm_ins_i   combinational program-memory address/data
//   ins_valid_o, ins_o, opcode_o, reg_sel_o, pc_o   presented instruction
//   halted_o             high while halted at END_ADDR
package instruction_fetch_pkg;
    localparam logic [3:0] OPCODE_NOP = 4'hF;
endpackage

module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int INS_W    = 6,
    parameter int OPC_W    = 4,
    parameter int END_ADDR = 31,
    parameter int SKIP_NOP = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run_i,
    input  logic                     stall_i,
    input  logic                     jump_en_i,
    input  logic [ADDR_W-1:0]        jump_addr_i,
    output logic [ADDR_W-1:0]        pm_addr_o,
    input  logic [INS_W-1:0]         pm_ins_i,
    output logic                     ins_valid_o,
    output logic [INS_W-1:0]         ins_o,
    output logic [OPC_W-1:0]         opcode_o,
    output logic [INS_W-OPC_W-1:0]   reg_sel_o,
    output logic [ADDR_W-1:0]        pc_o,
    output logic                     halted_o
);
    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              hold;
    logic              advance;
    logic              is_nop;

    assign hold      = ins_valid_o && stall_i;
    assign advance   = (state == FETCH) && run_i && !hold;
    assign is_nop    = (SKIP_NOP != 0) && (pm_ins_i[INS_W-1 -: OPC_W] == OPC_W'(OPCODE_NOP));
    assign pm_addr_o = pc;
    assign opcode_o  = ins_o[INS_W-1 -: OPC_W];
    assign reg_sel_o = ins_o[INS_W-OPC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            ins_valid_o <= 1'b0;
            ins_o       <= '0;
            pc_o        <= '0;
            halted_o    <= 1'b0;
        end else if (jump_en_i) begin
            pc          <= jump_addr_i;
            ins_valid_o <= 1'b0;
            if (state == HALT) begin
                state    <= FETCH;
                halted_o <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: if (run_i) state <= FETCH;
                FETCH: begin
                    if (advance) begin
                        ins_o       <= pm_ins_i;
                        pc_o        <= pc;
                        ins_valid_o <= !is_nop;
                        // PC parks at END_ADDR rather than wrapping
                        if (pc == ADDR_W'(END_ADDR)) begin
                            state    <= HALT;
                            halted_o <= 1'b1;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end else if (!run_i && !hold) begin
                        ins_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                HALT: if (!stall_i) ins_valid_o <= 1'b0;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed self-checking bench for instruction_fetch (plain and NOP-skipping).
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run0, stall0, jen0;
    logic [4:0] jaddr0;
    logic [4:0] pm_addr0, pc_o0;
    logic [5:0] pm_ins0, ins0;
    logic [3:0] opc0;
    logic [1:0] rsel0;
    logic       valid0, halted0;

    logic       run1, stall1, jen1;
    logic [4:0] jaddr1;
    logic [4:0] pm_addr1, pc_o1;
    logic [5:0] pm_ins1, ins1;
    logic [3:0] opc1;
    logic [1:0] rsel1;
    logic       valid1, halted1;

    logic [5:0] mem0 [32];
    logic [5:0] mem1 [32];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign pm_ins0 = mem0[pm_addr0];
    assign pm_ins1 = mem1[pm_addr1];

    instruction_fetch #(.SKIP_NOP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .run_i(run0), .stall_i(stall0),
        .jump_en_i(jen0), .jump_addr_i(jaddr0), .pm_addr_o(pm_addr0),
        .pm_ins_i(pm_ins0), .ins_valid_o(valid0), .ins_o(ins0),
        .opcode_o(opc0), .reg_sel_o(rsel0), .pc_o(pc_o0), .halted_o(halted0)
    );

    instruction_fetch #(.SKIP_NOP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .run_i(run1), .stall_i(stall1),
        .jump_en_i(jen1), .jump_addr_i(jaddr1), .pm_addr_o(pm_addr1),
        .pm_ins_i(pm_ins1), .ins_valid_o(valid1), .ins_o(ins1),
        .opcode_o(opc1), .reg_sel_o(rsel1), .pc_o(pc_o1), .halted_o(halted1)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int beats [$];
        int gaps;
        for (int i = 0; i < 32; i++) begin
            mem0[i] = 6'(i);
            mem1[i] = (i < 9 || i == 31) ? 6'(i) : {OPCODE_NOP, 2'b00};
        end
        rst_n = 1'b0;
        run0 = 0; stall0 = 0; jen0 = 0; jaddr0 = 0;
        run1 = 0; stall1 = 0; jen1 = 0; jaddr1 = 0;
        @(negedge clk);
        check("rst_valid", valid0, 0);
        check("rst_ins", ins0, 0);
        check("rst_pc_o", pc_o0, 0);
        check("rst_pm_addr", pm_addr0, 0);
        check("rst_halted", halted0, 0);
        check("rst_opcode", opc0, 0);
        check("rst_regsel", rsel0, 0);

        rst_n = 1'b1;
        run0 = 1'b1;
        step();
        check("idle2fetch_valid", valid0, 0);
        check("idle2fetch_pm_addr", pm_addr0, 0);
        step();
        check("first_valid", valid0, 1);
        check("first_ins", ins0, 0);
        check("first_pc_o", pc_o0, 0);
        check("first_pm_addr", pm_addr0, 1);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("seq_pc_o", pc_o0, k);
            check("seq_pm_addr", pm_addr0, k + 1);
            check("seq_valid", valid0, 1);
        end

        stall0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_ins", ins0, 3);
            check("stall_pc_o", pc_o0, 3);
            check("stall_pm_addr", pm_addr0, 4);
            check("stall_valid", valid0, 1);
        end
        stall0 = 1'b0;
        step();
        check("unstall_pc_o", pc_o0, 4);
        step();
        check("pre_jump_pc_o", pc_o0, 5);

        stall0 = 1'b1; jen0 = 1'b1; jaddr0 = 5'd20;
        step();
        check("jump_valid", valid0, 0);
        check("jump_pm_addr", pm_addr0, 20);
        stall0 = 1'b0; jen0 = 1'b0;
        step();
        check("jump_ins", ins0, 20);
        check("jump_pc_o", pc_o0, 20);
        check("jump_opcode", opc0, 5);
        check("jump_regsel", rsel0, 0);

        for (int k = 1; k <= 11; k++) begin
            step();
            check("tail_pc_o", pc_o0, 20 + k);
        end
        check("end_ins", ins0, 31);
        check("end_valid", valid0, 1);
        check("end_halted", halted0, 1);
        check("end_pm_addr", pm_addr0, 31);
        stall0 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check("halt_stall_valid", valid0, 1);
            check("halt_stall_pc_o", pc_o0, 31);
            check("halt_pm_addr", pm_addr0, 31);
            check("halt_halted", halted0, 1);
        end
        stall0 = 1'b0;
        step();
        check("halt_accept_valid", valid0, 0);
        check("halt_no_wrap_pc_o", pc_o0, 31);
        check("halt_hold_pm_addr", pm_addr0, 31);
        check("halt_still_halted", halted0, 1);

        jen0 = 1'b1; jaddr0 = 5'd0;
        step();
        check("exit_halted", halted0, 0);
        check("exit_pm_addr", pm_addr0, 0);
        check("exit_valid", valid0, 0);
        jen0 = 1'b0;
        step();
        check("resume_valid", valid0, 1);
        check("resume_pc_o", pc_o0, 0);
        for (int k = 1; k <= 10; k++) step();
        check("pre_reset_pc_o", pc_o0, 10);

        #2 rst_n = 1'b0;
        #1;
        check("async_valid", valid0, 0);
        check("async_ins", ins0, 0);
        check("async_pc_o", pc_o0, 0);
        check("async_pm_addr", pm_addr0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("restart_idle_valid", valid0, 0);
        step();
        check("restart_valid", valid0, 1);
        check("restart_pc_o", pc_o0, 0);

        run0 = 1'b0;
        run1 = 1'b1;
        gaps = 0;
        for (int c = 0; c < 80; c++) begin
            step();
            if (valid1) begin
                beats.push_back(int'(pc_o1));
                if (pc_o1 == 5'd31) break;
            end else if (beats.size() > 0) begin
                gaps++;
            end
        end
        check("skip_beats", beats.size(), 10);
        for (int i = 0; i < beats.size() && i < 10; i++)
            check("skip_beat_pc", beats[i], (i < 9) ? i : 31);
        check("skip_gaps", gaps, 22);
        check("skip_last_ins", ins1, 31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Sequential fetch stage that sits directly upstream of the 32-entry, 6-bit combinational program memory.
- Owns the program counter (PC) and drives the memory address.
- Registers the returned instruction into an instruction register and presents it, split into opcode and register fields, to the execute stage over a valid/stall handshake.
- Supports start/stop, an absolute jump with pipeline flush, optional NOP skipping, and halting at a configurable end address.

Parameters:
- ADDR_W, 5: PC and program-memory address width.
- INS_W, 6: instruction width.
- OPC_W, 4: opcode field width, taken from ins[INS_W-1:INS_W-OPC_W]; the register field is the remaining low bits.
- END_ADDR, 31: last address fetched before halting.
- SKIP_NOP, 0: when 1, NOP instructions (opcode equal to the shared OPCODE_NOP definition) are consumed without asserting ins_valid_o.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- run_i  input  1  level; 1 = fetch enabled.
- stall_i  input  1  downstream not ready; holds the presented instruction.
- jump_en_i  input  1  load PC from jump_addr_i and flush.
- jump_addr_i  input  ADDR_W  jump target.
- pm_addr_o  output  ADDR_W  program-memory address; always equal to the current PC.
- pm_ins_i  input  INS_W  program-memory data; combinational from pm_addr_o.
- ins_valid_o  output  1  ins_o, opcode_o, reg_sel_o and pc_o are valid.
- ins_o  output  INS_W  registered instruction.
- opcode_o  output  OPC_W  opcode field of ins_o.
- reg_sel_o  output  INS_W-OPC_W  register field of ins_o.
- pc_o  output  ADDR_W  address the presented instruction was fetched from.
- halted_o  output  1  1 while in HALT.

Behaviour:
- Reset (asynchronous, takes effect immediately on rst_n low):
  - PC=0, state IDLE.
  - ins_valid_o=0, ins_o=0, pc_o=0, halted_o=0.
  - opcode_o and reg_sel_o are 0, since they are slices of ins_o.
- States: IDLE, FETCH, HALT.
- advance = (state==FETCH) && run_i && !(ins_valid_o && stall_i).
- Priority at each edge: reset > jump_en_i > advance > hold.
- IDLE:
  - run_i=1 moves to FETCH at the next edge; no instruction is captured on that edge.
  - jump_en_i loads the PC; the block stays in IDLE.
- FETCH, on advance:
  - ins_o<=pm_ins_i, pc_o<=PC, PC<=PC+1.
  - ins_valid_o<=1, except ins_valid_o<=0 when SKIP_NOP=1 and the captured opcode is OPCODE_NOP.
  - Throughput is one instruction per cycle; latency is 1 cycle from pm_addr_o to ins_valid_o.
- FETCH, run_i=0:
  - No advance.
  - If ins_valid_o && stall_i, the presented instruction is held.
  - Otherwise ins_valid_o<=0 and the state returns to IDLE; the PC is preserved.
- Stall: while ins_valid_o && stall_i, ins_o, pc_o, PC and pm_addr_o hold. stall_i has no effect while ins_valid_o=0.
- Jump (any state other than reset): PC<=jump_addr_i and ins_valid_o<=0 at the same edge, regardless of stall_i.
  - From HALT: also returns to FETCH and clears halted_o.
  - From FETCH: stays in FETCH; the first new instruction appears one cycle after the jump edge.
- End of program: when advance occurs with PC==END_ADDR:
  - The instruction is captured normally.
  - The PC holds at END_ADDR (no wrap to 0).
  - The state moves to HALT; halted_o=1 from the next cycle.
- HALT:
  - No fetch; run_i is ignored.
  - The last instruction stays valid until accepted (a cycle with stall_i=0), then ins_valid_o<=0.
  - Exits only via jump_en_i or reset.
- Arithmetic: PC+1 is ADDR_W bits wide and is never used past END_ADDR. jump_addr_i > END_ADDR is legal: that address is fetched and fetching continues until the PC wraps (modulo 2^ADDR_W) to reach END_ADDR.
- Reset mid-stall or mid-HALT discards the held instruction.

Test Plan:
- Sequential fetch: bench memory Mem[i]=i, reset released, run_i=1 at cycle 0.
  - Cycle 1: state FETCH.
  - Cycle 2: ins_valid_o=1, ins_o=0, pc_o=0.
  - Then pc_o=1,2,3 on consecutive cycles; pm_addr_o always leads pc_o by 1.
- Stall: stall_i=1 for 3 cycles while pc_o=3.
  - ins_o=3, pc_o=3 and pm_addr_o=4 hold throughout.
  - First cycle after release: pc_o=4.
- Jump: jump_en_i=1, jump_addr_i=20 while pc_o=5 and stall_i=1.
  - Next cycle: ins_valid_o=0, pm_addr_o=20.
  - Following cycle: ins_o=20, pc_o=20.
- End/halt: run to the end.
  - pc_o=31, ins_o=31, ins_valid_o=1; halted_o=1 next cycle; pm_addr_o stays 31; no pc_o=0 appears.
  - With stall_i=1, valid persists; drop stall_i -> ins_valid_o=0 one edge later.
  - jump_en_i to 0 -> halted_o=0 and fetch resumes at address 0.
- SKIP_NOP=1, Mem[9..30]=NOP.
  - Valid beats carry pc_o=0..8, then 31 only.
  - 22 cycles with ins_valid_o=0 in between.
- Asynchronous reset mid-run: drop rst_n between edges while pc_o=10.
  - ins_valid_o, ins_o, pc_o and pm_addr_o go to 0 before the next edge.
  - After release with run_i=1, fetch restarts at address 0.
